// File: rtl/gpio_intr_arb.sv
// rtl/gpio_intr_arb.sv - GPIO interrupt edge capture, fixed-priority arbiter and req/ack front end
module gpio_intr_arb #(
  parameter int unsigned NSRC    = 32,
  parameter int unsigned IDW     = 5,
  parameter int unsigned HOLDOFF = 4
) (
  input  logic            mclk,
  input  logic            h_reset,
  input  logic [NSRC-1:0] gpio_intr,
  input  logic [NSRC-1:0] cfg_src_en,
  input  logic            cfg_prio_hi,
  input  logic [NSRC-1:0] pend_clr,
  output logic            irq_req,
  output logic [IDW-1:0]  irq_id,
  input  logic            irq_ack,
  output logic [NSRC-1:0] pend_status,
  output logic [NSRC-1:0] ovr_status
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Counter reload value; HOLDOFF=0 never enters HOLD so the value is unused then.
  localparam int unsigned HOLD_LOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

  state_t            state_q, state_d;
  logic [NSRC-1:0]   intr_d1_q;
  logic [NSRC-1:0]   pend_q, pend_d;
  logic [NSRC-1:0]   ovr_q, ovr_d;
  logic [IDW-1:0]    irq_id_q, irq_id_d;
  logic              irq_req_q, irq_req_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [NSRC-1:0]   edge_v;
  logic              ack_hit;
  logic [NSRC-1:0]   ack_mask;
  logic [NSRC-1:0]   cand_all;
  logic [NSRC-1:0]   cand_ack;

  // Fixed-priority encoder: hi=1 picks the highest set index, hi=0 the lowest.
  function automatic logic [IDW-1:0] pick(input logic [NSRC-1:0] v, input logic hi);
    logic [IDW-1:0] r;
    r = '0;
    if (hi) begin
      for (int i = 0; i < NSRC; i++) begin
        if (v[i]) r = IDW'(i);
      end
    end else begin
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (v[i]) r = IDW'(i);
      end
    end
    return r;
  endfunction

  // Edge detect, ack clear mask and arbitration candidate sets.
  always_comb begin
    edge_v   = gpio_intr & ~intr_d1_q & cfg_src_en;
    ack_hit  = (state_q == S_REQ) && irq_ack;
    ack_mask = ack_hit ? ({{(NSRC-1){1'b0}}, 1'b1} << irq_id_q) : '0;
    cand_all = pend_q & cfg_src_en;
    cand_ack = pend_q & ~ack_mask & cfg_src_en;
  end

  // Pending and sticky overrun update; a fresh edge beats both SW clear and ack clear.
  always_comb begin
    pend_d = (pend_q & ~pend_clr & ~ack_mask) | edge_v;
    ovr_d  = (ovr_q & ~(pend_clr & ~edge_v))
           | (edge_v & pend_q & ~pend_clr & ~ack_mask);
  end

  // Handshake FSM: IDLE arbitrates, REQ waits for ack or withdraw, HOLD enforces the gap.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|cand_all) begin
          irq_id_d = pick(cand_all, cfg_prio_hi);
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (irq_ack) begin
          if (HOLDOFF == 0) begin
            // No gap wanted: hand the next winner straight over.
            if (|cand_ack) begin
              irq_id_d = pick(cand_ack, cfg_prio_hi);
              state_d  = S_REQ;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d   = 8'(HOLD_LOAD);
            state_d = S_HOLD;
          end
        end else if (pend_clr[irq_id_q]) begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          // Last quiet cycle: re-arbitrate here so the gap is exactly HOLDOFF cycles.
          if (|cand_all) begin
            irq_id_d = pick(cand_all, cfg_prio_hi);
            state_d  = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    irq_req_d = (state_d == S_REQ);
  end

  // State, status and output registers.
  always_ff @(posedge mclk or posedge h_reset) begin
    if (h_reset) begin
      state_q   <= S_IDLE;
      intr_d1_q <= '0;
      pend_q    <= '0;
      ovr_q     <= '0;
      irq_id_q  <= '0;
      irq_req_q <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      intr_d1_q <= gpio_intr;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      irq_id_q  <= irq_id_d;
      irq_req_q <= irq_req_d;
      cnt_q     <= cnt_d;
    end
  end

  assign irq_req     = irq_req_q;
  assign irq_id      = irq_id_q;
  assign pend_status = pend_q;
  assign ovr_status  = ovr_q;

endmodule

// File: tb/tb_gpio_intr_arb.sv
// tb/tb_gpio_intr_arb.sv - directed vector bench for gpio_intr_arb
module tb_gpio_intr_arb;

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  logic        mclk;
  logic        h_reset;
  logic [31:0] gpio_intr;
  logic [31:0] cfg_src_en;
  logic        cfg_prio_hi;
  logic [31:0] pend_clr;
  logic        irq_ack;

  logic        irq_req, irq_req0;
  logic [4:0]  irq_id, irq_id0;
  logic [31:0] pend_status, pend_status0;
  logic [31:0] ovr_status, ovr_status0;

  int n_vec;
  int n_miss;

  typedef struct {
    logic [31:0] gpio;
    logic [31:0] en;
    logic        ph;
    logic [31:0] clr;
    logic        ack;
    logic        req;
    logic [4:0]  id;
    logic [31:0] pend;
    logic [31:0] ovr;
  } vec_t;

  vec_t vecs[$];

  gpio_intr_arb #(.NSRC(32), .IDW(5), .HOLDOFF(4)) dut (
    .mclk        (mclk),
    .h_reset     (h_reset),
    .gpio_intr   (gpio_intr),
    .cfg_src_en  (cfg_src_en),
    .cfg_prio_hi (cfg_prio_hi),
    .pend_clr    (pend_clr),
    .irq_req     (irq_req),
    .irq_id      (irq_id),
    .irq_ack     (irq_ack),
    .pend_status (pend_status),
    .ovr_status  (ovr_status)
  );

  gpio_intr_arb #(.NSRC(32), .IDW(5), .HOLDOFF(0)) dut0 (
    .mclk        (mclk),
    .h_reset     (h_reset),
    .gpio_intr   (gpio_intr),
    .cfg_src_en  (cfg_src_en),
    .cfg_prio_hi (cfg_prio_hi),
    .pend_clr    (pend_clr),
    .irq_req     (irq_req0),
    .irq_id      (irq_id0),
    .irq_ack     (irq_ack),
    .pend_status (pend_status0),
    .ovr_status  (ovr_status0)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic [31:0] g, input logic [31:0] e, input logic ph,
                      input logic [31:0] c, input logic a);
    gpio_intr   = g;
    cfg_src_en  = e;
    cfg_prio_hi = ph;
    pend_clr    = c;
    irq_ack     = a;
    @(negedge mclk);
  endtask

  task automatic chk_main(input string nm, input logic r, input logic [4:0] id,
                          input logic [31:0] p, input logic [31:0] o);
    chk({nm, " req"}, 32'(irq_req), 32'(r));
    chk({nm, " id"}, 32'(irq_id), 32'(id));
    chk({nm, " pend"}, pend_status, p);
    chk({nm, " ovr"}, ovr_status, o);
  endtask

  task automatic chk_h0(input string nm, input logic r, input logic [4:0] id,
                        input logic [31:0] p);
    chk({nm, " req0"}, 32'(irq_req0), 32'(r));
    chk({nm, " id0"}, 32'(irq_id0), 32'(id));
    chk({nm, " pend0"}, pend_status0, p);
  endtask

  function automatic void av(input logic [31:0] g, input logic [31:0] e, input logic ph,
                             input logic [31:0] c, input logic a, input logic r,
                             input logic [4:0] id, input logic [31:0] p, input logic [31:0] o);
    vecs.push_back('{gpio: g, en: e, ph: ph, clr: c, ack: a, req: r, id: id, pend: p, ovr: o});
  endfunction

  initial begin
    n_vec  = 0;
    n_miss = 0;

    // T1: single source edge -> pending -> request -> ack -> hold-off
    av(32'h8, ALL, 0, 0, 0, 0, 0, 32'h8, 0);
    av(32'h8, ALL, 0, 0, 0, 1, 3, 32'h8, 0);
    av(32'h8, ALL, 0, 0, 1, 0, 3, 32'h0, 0);
    for (int i = 0; i < 4; i++) av(32'h0, ALL, 0, 0, 0, 0, 3, 32'h0, 0);
    // T2: two sources, lowest index first, exactly 4 quiet cycles after ack
    av(32'h10010, ALL, 0, 0, 0, 0, 3, 32'h10010, 0);
    av(32'h10010, ALL, 0, 0, 0, 1, 4, 32'h10010, 0);
    av(32'h10010, ALL, 0, 0, 1, 0, 4, 32'h10000, 0);
    for (int i = 0; i < 3; i++) av(32'h10010, ALL, 0, 0, 0, 0, 4, 32'h10000, 0);
    av(32'h10010, ALL, 0, 0, 0, 1, 16, 32'h10000, 0);
    av(32'h0, ALL, 0, 0, 1, 0, 16, 32'h0, 0);
    for (int i = 0; i < 4; i++) av(32'h0, ALL, 0, 0, 0, 0, 16, 32'h0, 0);
    // T2 again with highest index winning
    av(32'h10010, ALL, 1, 0, 0, 0, 16, 32'h10010, 0);
    av(32'h10010, ALL, 1, 0, 0, 1, 16, 32'h10010, 0);
    av(32'h10010, ALL, 1, 0, 1, 0, 16, 32'h10, 0);
    for (int i = 0; i < 3; i++) av(32'h10010, ALL, 1, 0, 0, 0, 16, 32'h10, 0);
    av(32'h10010, ALL, 1, 0, 0, 1, 4, 32'h10, 0);
    av(32'h0, ALL, 1, 0, 1, 0, 4, 32'h0, 0);
    for (int i = 0; i < 4; i++) av(32'h0, ALL, 1, 0, 0, 0, 4, 32'h0, 0);
    // T5: disabled source is not captured; ack while idle is ignored
    av(32'h200, ~32'h200, 0, 0, 0, 0, 4, 32'h0, 0);
    av(32'h200, ~32'h200, 0, 0, 0, 0, 4, 32'h0, 0);
    av(32'h0, ALL, 0, 0, 1, 0, 4, 32'h0, 0);

    h_reset     = 1'b1;
    gpio_intr   = '0;
    cfg_src_en  = ALL;
    cfg_prio_hi = 1'b0;
    pend_clr    = '0;
    irq_ack     = 1'b0;
    @(negedge mclk);
    @(negedge mclk);
    chk_main("reset", 0, 0, 0, 0);
    chk("reset req0", 32'(irq_req0), 32'd0);
    h_reset = 1'b0;

    foreach (vecs[k]) begin
      step(vecs[k].gpio, vecs[k].en, vecs[k].ph, vecs[k].clr, vecs[k].ack);
      chk_main($sformatf("v%0d", k), vecs[k].req, vecs[k].id, vecs[k].pend, vecs[k].ovr);
    end

    // T3: second edge without ack sets overrun; pend_clr withdraws the request
    step(32'h80, ALL, 0, 0, 0);       chk_main("t3a", 0, 4, 32'h80, 0);
    step(32'h0, ALL, 0, 0, 0);        chk_main("t3b", 1, 7, 32'h80, 0);
    step(32'h80, ALL, 0, 0, 0);       chk_main("t3c", 1, 7, 32'h80, 32'h80);
    step(32'h0, ALL, 0, 32'h80, 0);   chk_main("t3d", 0, 7, 32'h0, 0);
    step(32'h0, ALL, 0, 0, 0);        chk_main("t3e", 0, 7, 32'h0, 0);

    // T4: ack and a new edge on the same id in one cycle keeps it pending
    step(32'h20, ALL, 0, 0, 0);       chk_main("t4a", 0, 7, 32'h20, 0);
    step(32'h0, ALL, 0, 0, 0);        chk_main("t4b", 1, 5, 32'h20, 0);
    step(32'h20, ALL, 0, 0, 1);       chk_main("t4c", 0, 5, 32'h20, 0);
    for (int i = 0; i < 3; i++) begin
      step(32'h20, ALL, 0, 0, 0);     chk_main($sformatf("t4hold%0d", i), 0, 5, 32'h20, 0);
    end
    step(32'h20, ALL, 0, 0, 0);       chk_main("t4d", 1, 5, 32'h20, 0);
    step(32'h0, ALL, 0, 0, 1);        chk_main("t4e", 0, 5, 32'h0, 0);
    for (int i = 0; i < 4; i++) step(32'h0, ALL, 0, 0, 0);

    // T5: asynchronous reset during REQ
    step(32'h4, ALL, 0, 0, 0);        chk_main("t5a", 0, 5, 32'h4, 0);
    step(32'h4, ALL, 0, 0, 0);        chk_main("t5b", 1, 2, 32'h4, 0);
    gpio_intr = '0;
    #2 h_reset = 1'b1;
    #1 chk_main("t5rst", 0, 0, 0, 0);
    @(negedge mclk);
    h_reset = 1'b0;

    // T6: HOLDOFF=0 build hands over to the next source right after each ack
    step(32'h111, ALL, 0, 0, 0);      chk_h0("t6a", 0, 0, 32'h111);
    step(32'h111, ALL, 0, 0, 0);      chk_h0("t6b", 1, 0, 32'h111);
    step(32'h111, ALL, 0, 0, 1);      chk_h0("t6c", 1, 4, 32'h110);
    step(32'h111, ALL, 0, 0, 1);      chk_h0("t6d", 1, 8, 32'h100);
    step(32'h111, ALL, 0, 0, 1);      chk_h0("t6e", 0, 8, 32'h0);
    step(32'h111, ALL, 0, 0, 0);      chk_h0("t6f", 0, 8, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
